ball_motion: RTL and testbench



---
 rtl/pong_pkg.sv | 26 ++
 rtl/sprite_pkg.sv | 9 +
 rtl/vga_pkg.sv | 5 +
 rtl/sprite_if.sv | 7 +
 rtl/ball_axis_step.sv | 47 ++++
 rtl/ball_motion.sv | 156 +++++++++++++++
 tb/tb_ball_motion.sv | 259 +++++++++++++++++++++++++
 7 files changed

// File: rtl/pong_pkg.sv
// Pong game-state enums and default playfield geometry.
package pong_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        PLAY   = 2'd2,
        SCORED = 2'd3
    } ball_state_e;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    localparam dir_e DIR_LEFT  = DIR_DEC;
    localparam dir_e DIR_RIGHT = DIR_INC;
    localparam dir_e DIR_UP    = DIR_DEC;
    localparam dir_e DIR_DOWN  = DIR_INC;

    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int BALL_SIZE_DEF    = 8;
    localparam int SPEED_X_DEF      = 2;
    localparam int SPEED_Y_DEF      = 2;
    localparam int SERVE_FRAMES_DEF = 60;
endpackage

// File: rtl/sprite_pkg.sv
// Sprite bounding box as seen by the renderer and the collision checkers.
package sprite_pkg;
    typedef struct packed {
        logic [vga_pkg::X_POS_W-1:0] x_pos;
        logic [vga_pkg::Y_POS_W-1:0] y_pos;
        logic [vga_pkg::X_POS_W-1:0] right;
        logic [vga_pkg::Y_POS_W-1:0] bottom;
    } sprite_t;
endpackage

// File: rtl/vga_pkg.sv
// Display timing widths shared by every sprite-level block.
package vga_pkg;
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;
endpackage

// File: rtl/sprite_if.sv
// Sprite position bus; master drives the box, renderers/collision checkers observe it.
interface sprite_if;
    sprite_pkg::sprite_t spr;

    modport master (output spr);
    modport slave  (input  spr);
endinterface

// File: rtl/ball_axis_step.sv
// One-axis position step with edge detect: combinational, no backpressure.
// CLAMP=1 pins the position to the wall on an edge; CLAMP=0 holds it and only flags.
module ball_axis_step #(
    parameter int W     = 10,
    parameter int LIMIT = 632,
    parameter int SPEED = 2,
    parameter bit CLAMP = 1'b1
) (
    input  logic [W-1:0] pos_i,
    input  logic         inc_i,
    output logic [W-1:0] pos_o,
    output logic         edge_o
);
    localparam int            WE      = W + 1;
    localparam logic [W:0]    SPEED_E = WE'(SPEED);
    localparam logic [W:0]    LIMIT_E = WE'(LIMIT);
    localparam logic [W-1:0]  LIMIT_W = W'(LIMIT);

    // One spare bit so pos+SPEED near the top of the range cannot wrap.
    logic [W:0] pos_e;
    logic [W:0] pos_up;
    logic [W:0] pos_dn;

    assign pos_e  = {1'b0, pos_i};
    assign pos_up = pos_e + SPEED_E;
    assign pos_dn = pos_e - SPEED_E;

    always_comb begin
        pos_o  = pos_i;
        edge_o = 1'b0;
        if (inc_i) begin
            if (pos_up >= LIMIT_E) begin
                edge_o = 1'b1;
                if (CLAMP) pos_o = LIMIT_W;
            end else begin
                pos_o = pos_up[W-1:0];
            end
        end else begin
            if (pos_e <= SPEED_E) begin
                edge_o = 1'b1;
                if (CLAMP) pos_o = '0;
            end else begin
                pos_o = pos_dn[W-1:0];
            end
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Ball mover: idle/serve/play sequencing, wall and paddle reflection, goal pulses.
// Outputs update one cycle after frame_tick_i; no backpressure (collisions are latched until the tick).
module ball_motion
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int SPEED_X      = SPEED_X_DEF,
    parameter int SPEED_Y      = SPEED_Y_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic       collide_left_i,
    input  logic       collide_right_i,
    sprite_if.master   ball_o,
    output logic       score_left_o,
    output logic       score_right_o,
    output logic [1:0] state_o
);
    localparam int X_W   = vga_pkg::X_POS_W;
    localparam int Y_W   = vga_pkg::Y_POS_W;
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [X_W-1:0]   X_CTR    = X_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [Y_W-1:0]   Y_CTR    = Y_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [X_W-1:0]   BALL_X   = X_W'(BALL_SIZE);
    localparam logic [Y_W-1:0]   BALL_Y   = Y_W'(BALL_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam sprite_pkg::sprite_t SPR_CTR = '{
        x_pos: X_CTR, y_pos: Y_CTR, right: X_CTR + BALL_X, bottom: Y_CTR + BALL_Y};

    ball_state_e         state_q, state_d;
    sprite_pkg::sprite_t spr_q, spr_d;
    dir_e                dx_q, dx_d, dy_q, dy_d, dx_new;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lat_l_q, lat_l_d, lat_r_q, lat_r_d;
    logic                score_l_q, score_l_d, score_r_q, score_r_d;
    logic [X_W-1:0]      x_d, x_step;
    logic [Y_W-1:0]      y_d, y_step;
    logic                hit_l, hit_r, flip_r, flip_l, x_edge, y_edge, goal;

    // A paddle only acts when the ball is heading into it, so a held overlap cannot re-flip.
    assign hit_l  = lat_l_q | collide_left_i;
    assign hit_r  = lat_r_q | collide_right_i;
    assign flip_r = hit_l && (dx_q == DIR_LEFT);
    assign flip_l = hit_r && (dx_q == DIR_RIGHT);
    assign dx_new = flip_r ? DIR_RIGHT : (flip_l ? DIR_LEFT : dx_q);
    assign goal   = x_edge && !(flip_r || flip_l);

    ball_axis_step #(
        .W(X_W), .LIMIT(SCREEN_W - BALL_SIZE), .SPEED(SPEED_X), .CLAMP(1'b0)
    ) u_step_x (
        .pos_i (spr_q.x_pos),
        .inc_i (dx_new),
        .pos_o (x_step),
        .edge_o(x_edge)
    );

    ball_axis_step #(
        .W(Y_W), .LIMIT(SCREEN_H - BALL_SIZE), .SPEED(SPEED_Y), .CLAMP(1'b1)
    ) u_step_y (
        .pos_i (spr_q.y_pos),
        .inc_i (dy_q),
        .pos_o (y_step),
        .edge_o(y_edge)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = spr_q.x_pos;
        y_d       = spr_q.y_pos;
        dx_d      = dx_q;
        dy_d      = dy_q;
        cnt_d     = cnt_q;
        lat_l_d   = frame_tick_i ? 1'b0 : hit_l;
        lat_r_d   = frame_tick_i ? 1'b0 : hit_r;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_tick_i && start_i) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                if (frame_tick_i) begin
                    if (cnt_q == CNT_LAST) state_d = PLAY;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick_i) begin
                    if (goal) begin
                        state_d   = SCORED;
                        score_l_d = (dx_new == DIR_RIGHT);
                        score_r_d = (dx_new == DIR_LEFT);
                    end else begin
                        x_d  = x_step;
                        dx_d = dx_new;
                        y_d  = y_step;
                        dy_d = y_edge ? ((dy_q == DIR_UP) ? DIR_DOWN : DIR_UP) : dy_q;
                    end
                end
            end
            SCORED: begin
                // Next serve heads toward the player who just conceded.
                state_d = SERVE;
                cnt_d   = '0;
                x_d     = X_CTR;
                y_d     = Y_CTR;
                dx_d    = score_r_q ? DIR_LEFT : DIR_RIGHT;
            end
            default: state_d = IDLE;
        endcase

        spr_d.x_pos  = x_d;
        spr_d.y_pos  = y_d;
        spr_d.right  = x_d + BALL_X;
        spr_d.bottom = y_d + BALL_Y;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            spr_q     <= SPR_CTR;
            dx_q      <= DIR_RIGHT;
            dy_q      <= DIR_DOWN;
            cnt_q     <= '0;
            lat_l_q   <= 1'b0;
            lat_r_q   <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            spr_q     <= spr_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            cnt_q     <= cnt_d;
            lat_l_q   <= lat_l_d;
            lat_r_q   <= lat_r_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign ball_o.spr    = spr_q;
    assign score_left_o  = score_l_q;
    assign score_right_o = score_r_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed vector table, hand-built corner sequences, then random play against a rule-level model.
module tb_ball_motion;
    localparam int SF = 4;
    localparam int SW = 640;
    localparam int SH = 480;
    localparam int BS = 8;
    localparam int SP = 2;
    localparam int CX = (SW - BS) / 2;
    localparam int CY = (SH - BS) / 2;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_SCORED = 3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_tick_i = 1'b0;
    logic       start_i = 1'b0;
    logic       collide_left_i = 1'b0;
    logic       collide_right_i = 1'b0;
    logic       score_left_o, score_right_o;
    logic [1:0] state_o;

    sprite_if ball_if();

    ball_motion #(.SERVE_FRAMES(SF)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .frame_tick_i   (frame_tick_i),
        .start_i        (start_i),
        .collide_left_i (collide_left_i),
        .collide_right_i(collide_right_i),
        .ball_o         (ball_if),
        .score_left_o   (score_left_o),
        .score_right_o  (score_right_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: ball as integer position plus signed velocity.
    int mst, mx, my, vx, vy, mcnt;
    bit pl, pr, msl, msr;

    typedef struct {
        bit tk, st, cl, cr;
        int x, y, s;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = S_IDLE; mx = CX; my = CY; vx = SP; vy = SP; mcnt = 0;
        pl = 1'b0; pr = 1'b0; msl = 1'b0; msr = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit st, input bit cl, input bit cr);
        bit hl, hr, nsl, nsr, flipped;
        hl = pl | cl;
        hr = pr | cr;
        nsl = 1'b0;
        nsr = 1'b0;
        if (mst == S_SCORED) begin
            mx = CX; my = CY;
            vx = msr ? -SP : SP;
            mst = S_SERVE; mcnt = 0;
        end else if (tk) begin
            case (mst)
                S_IDLE:  if (st) begin mst = S_SERVE; mcnt = 0; end
                S_SERVE: if (mcnt == SF - 1) mst = S_PLAY; else mcnt++;
                S_PLAY: begin
                    flipped = 1'b0;
                    if (hl && vx < 0)      begin vx = SP;  flipped = 1'b1; end
                    else if (hr && vx > 0) begin vx = -SP; flipped = 1'b1; end
                    if (!flipped && vx < 0 && mx <= SP) begin
                        nsr = 1'b1; mst = S_SCORED;
                    end else if (!flipped && vx > 0 && mx + BS + SP >= SW) begin
                        nsl = 1'b1; mst = S_SCORED;
                    end else begin
                        mx += vx;
                        if (vy < 0 && my <= SP)                begin my = 0;       vy = SP;  end
                        else if (vy > 0 && my + BS + SP >= SH) begin my = SH - BS; vy = -SP; end
                        else my += vy;
                    end
                end
                default: ;
            endcase
        end
        if (tk) begin pl = 1'b0; pr = 1'b0; end
        else    begin pl = hl;   pr = hr;   end
        msl = nsl;
        msr = nsr;
    endtask

    task automatic chk_model();
        chk("model.x",      int'(ball_if.spr.x_pos),  mx);
        chk("model.y",      int'(ball_if.spr.y_pos),  my);
        chk("model.right",  int'(ball_if.spr.right),  mx + BS);
        chk("model.bottom", int'(ball_if.spr.bottom), my + BS);
        chk("model.state",  int'(state_o),            mst);
        chk("model.scoreL", int'(score_left_o),       int'(msl));
        chk("model.scoreR", int'(score_right_o),      int'(msr));
    endtask

    // One clock: inputs applied at negedge, outputs inspected at the following negedge.
    task automatic cyc(input bit tk, input bit st, input bit cl, input bit cr, input bit cmp);
        frame_tick_i = tk; start_i = st; collide_left_i = cl; collide_right_i = cr;
        @(posedge clk_i);
        model_step(tk, st, cl, cr);
        @(negedge clk_i);
        frame_tick_i = 1'b0; start_i = 1'b0; collide_left_i = 1'b0; collide_right_i = 1'b0;
        if (cmp) chk_model();
    endtask

    task automatic tick1();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick_until_x(input int tgt);
        int k;
        k = 0;
        while (int'(ball_if.spr.x_pos) != tgt && k < 500) begin
            tick1();
            k++;
        end
        chk("reach_x", int'(ball_if.spr.x_pos), tgt);
    endtask

    task automatic tick_until_y(input int tgt);
        int k;
        k = 0;
        while (int'(ball_if.spr.y_pos) != tgt && k < 500) begin
            tick1();
            k++;
        end
        chk("reach_y", int'(ball_if.spr.y_pos), tgt);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, CX,  CY,  S_IDLE};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, CX,  CY,  S_IDLE};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, CX,  CY,  S_IDLE};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, CX,  CY,  S_SERVE};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, CX,  CY,  S_SERVE};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, CX,  CY,  S_SERVE};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, CX,  CY,  S_SERVE};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, CX,  CY,  S_SERVE};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, CX,  CY,  S_PLAY};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 318, 238, S_PLAY};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 318, 238, S_PLAY};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 320, 240, S_PLAY};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 318, 242, S_PLAY};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 318, 242, S_PLAY};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 316, 244, S_PLAY};

        model_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].tk, tbl[i].st, tbl[i].cl, tbl[i].cr, 1'b0);
            chk($sformatf("vec%0d.x", i),      int'(ball_if.spr.x_pos),  tbl[i].x);
            chk($sformatf("vec%0d.y", i),      int'(ball_if.spr.y_pos),  tbl[i].y);
            chk($sformatf("vec%0d.right", i),  int'(ball_if.spr.right),  tbl[i].x + BS);
            chk($sformatf("vec%0d.bottom", i), int'(ball_if.spr.bottom), tbl[i].y + BS);
            chk($sformatf("vec%0d.state", i),  int'(state_o),            tbl[i].s);
            chk($sformatf("vec%0d.scores", i), int'({score_left_o, score_right_o}), 0);
        end

        // Bottom wall from (316,244) heading left/down.
        tick_until_y(470);
        chk("bot.x", int'(ball_if.spr.x_pos), 90);
        tick1();
        chk("bot.clamp", int'(ball_if.spr.y_pos), 472);
        tick1();
        chk("bot.up", int'(ball_if.spr.y_pos), 470);

        // Left paddle: mid-frame pulse, then held high across the next tick.
        tick_until_x(40);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("padL.flip", int'(ball_if.spr.x_pos), 42);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("padL.held", int'(ball_if.spr.x_pos), 44);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Top wall.
        tick_until_y(2);
        chk("top.x", int'(ball_if.spr.x_pos), 462);
        tick1();
        chk("top.clamp", int'(ball_if.spr.y_pos), 0);
        tick1();
        chk("top.down", int'(ball_if.spr.y_pos), 2);

        // Right paddle hit on the tick cycle itself.
        tick_until_x(600);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("padR.tick", int'(ball_if.spr.x_pos), 598);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Goal on the left edge.
        tick_until_x(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("goal.state", int'(state_o), S_SCORED);
        chk("goal.scoreR", int'(score_right_o), 1);
        chk("goal.scoreL", int'(score_left_o), 0);
        chk("goal.xhold", int'(ball_if.spr.x_pos), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("goal.pulse_end", int'(score_right_o), 0);
        chk("goal.serve", int'(state_o), S_SERVE);
        chk("goal.cx", int'(ball_if.spr.x_pos), CX);
        chk("goal.cy", int'(ball_if.spr.y_pos), CY);
        repeat (SF) tick1();
        chk("reserve.play", int'(state_o), S_PLAY);
        chk("reserve.hold", int'(ball_if.spr.x_pos), CX);
        tick1();
        chk("reserve.left", int'(ball_if.spr.x_pos), CX - SP);

        // Asynchronous reset between clock edges during play.
        #2 rst_i = 1'b1;
        #1;
        chk("arst.state",  int'(state_o), S_IDLE);
        chk("arst.x",      int'(ball_if.spr.x_pos), CX);
        chk("arst.y",      int'(ball_if.spr.y_pos), CY);
        chk("arst.right",  int'(ball_if.spr.right), CX + BS);
        chk("arst.bottom", int'(ball_if.spr.bottom), CY + BS);
        chk("arst.scores", int'({score_left_o, score_right_o}), 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) tick1();
        chk("arst.stay_idle", int'(state_o), S_IDLE);

        // Random play.
        for (int t = 0; t < 2500; t++) begin
            int gap;
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++)
                cyc(1'b0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 149) == 0), 1'b1);
            cyc(1'b1, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 149) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
